sccb_init_ctrl: RTL and testbench

//  Camera register-init sequencer. Walks a ROM table of {reg_addr,value} pairs and feeds each pair to

---
 rtl/sccb_init_ctrl_pkg.sv | 25 ++
 rtl/sccb_init_ctrl_rom.sv | 60 ++++++
 rtl/sccb_init_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sccb_init_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_ctrl_pkg.sv
// Shared types and constants for the camera register-init sequencer.
// Table markers, the default camera write address and the FSM state encoding.
package sccb_init_ctrl_pkg;

  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK   = 16'hFFF0;
  localparam logic [7:0]  DEF_SLAVE_ID = 8'h42;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StFetch,
    StDecode,
    StIssue,
    StGap,
    StDly,
    StDone,
    StError
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !(s inside {StIdle, StDone, StError});
  endfunction

endpackage

// File: rtl/sccb_init_ctrl_rom.sv
// Synchronous ROM of {reg_addr, value} pairs for camera bring-up.
// TEST_TABLE selects a short table used for fast simulation instead of the camera settings.
module sccb_init_ctrl_rom
  import sccb_init_ctrl_pkg::*;
#(
  parameter int unsigned ROM_DEPTH  = 128,
  parameter int unsigned IDX_W      = $clog2(ROM_DEPTH),
  parameter bit          TEST_TABLE = 1'b0
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output logic [15:0]      data
);

  logic [15:0] word;

  always_comb begin
    word = END_MARK;
    if (TEST_TABLE) begin
      case (int'(addr))
        0:       word = 16'h1280;
        1:       word = DELAY_MARK;
        2:       word = 16'h1101;
        3:       word = 16'h40D0;
        default: word = END_MARK;
      endcase
    end else begin
      // Soft reset first; the camera needs the delay entry before it accepts writes again.
      case (int'(addr))
        0:       word = 16'h1280;
        1:       word = DELAY_MARK;
        2:       word = 16'h1204;
        3:       word = 16'h1101;
        4:       word = 16'h0C00;
        5:       word = 16'h3E00;
        6:       word = 16'h40D0;
        7:       word = 16'h8C00;
        8:       word = 16'h3A04;
        9:       word = 16'h3DC0;
        10:      word = 16'h1713;
        11:      word = 16'h1801;
        12:      word = 16'h32B6;
        13:      word = 16'h1902;
        14:      word = 16'h1A7A;
        15:      word = 16'h030A;
        16:      word = 16'h703A;
        17:      word = 16'h7135;
        18:      word = 16'h7211;
        19:      word = 16'h73F0;
        20:      word = 16'hA202;
        default: word = END_MARK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data <= word;
  end

endmodule

// File: rtl/sccb_init_ctrl.sv
// Camera register-init sequencer: walks the ROM table and hands each pair to the SCCB sender,
// pacing writes so a new transfer never starts before the previous frame has finished.
module sccb_init_ctrl
  import sccb_init_ctrl_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ID   = DEF_SLAVE_ID,
  parameter int unsigned ROM_DEPTH  = 128,
  parameter int unsigned PWRUP_CYC  = 25000,
  parameter int unsigned XFER_CYC   = 65536,
  parameter int unsigned DELAY_CYC  = 250000,
  parameter int unsigned ACK_TMO    = 16,
  parameter int unsigned CNT_W      = 20,
  parameter bit          TEST_TABLE = 1'b0,
  localparam int unsigned IDX_W     = $clog2(ROM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             reg_ok,
  input  logic             sccb_ok,
  output logic [7:0]       slave_id,
  output logic [7:0]       reg_addr,
  output logic [7:0]       value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cur_index
);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W:0]   IDX_ONE    = (IDX_W + 1)'(1);

  localparam longint unsigned CNT_SPAN = longint'(1) << CNT_W;
  localparam bit CNT_FITS = (longint'(PWRUP_CYC) <= CNT_SPAN) && (longint'(XFER_CYC) <= CNT_SPAN)
                         && (longint'(DELAY_CYC) <= CNT_SPAN) && (longint'(ACK_TMO) <= CNT_SPAN);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // One extra bit so reaching ROM_DEPTH is detectable instead of wrapping to entry 0.
  logic [IDX_W:0] idx_q, idx_d;
  logic [7:0]     reg_addr_q, reg_addr_d;
  logic [7:0]     value_q, value_d;
  logic           reg_ok_q, busy_q, done_q, error_q;
  logic [15:0]    rom_data;

  sccb_init_ctrl_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .IDX_W     (IDX_W),
    .TEST_TABLE(TEST_TABLE)
  ) u_rom (
    .clk (clk),
    .addr(idx_q[IDX_W-1:0]),
    .data(rom_data)
  );

  always_comb begin
    assert (CNT_FITS) else $error("CNT_W too narrow for the configured wait lengths");
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    reg_addr_d = reg_addr_q;
    value_d    = value_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StPwrup;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StPwrup: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StFetch: begin
        state_d = idx_q[IDX_W] ? StError : StDecode;
      end
      StDecode: begin
        if (rom_data == END_MARK) begin
          state_d = StDone;
        end else if (rom_data == DELAY_MARK) begin
          state_d = StDly;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_ONE;
        end else begin
          state_d    = StIssue;
          cnt_d      = '0;
          reg_addr_d = rom_data[15:8];
          value_d    = rom_data[7:0];
        end
      end
      StIssue: begin
        // The handshake takes priority over the timeout on the last allowed cycle.
        if (sccb_ok) begin
          state_d = StGap;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_ONE;
        end else if (cnt_q == ACK_LAST) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StGap: begin
        if (cnt_q == XFER_LAST) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StDly: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      reg_addr_q <= '0;
      value_q    <= '0;
      reg_ok_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      reg_addr_q <= reg_addr_d;
      value_q    <= value_d;
      reg_ok_q   <= (state_d == StIssue);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StError);
    end
  end

  assign slave_id  = SLAVE_ID;
  assign reg_ok    = reg_ok_q;
  assign reg_addr  = reg_addr_q;
  assign value     = value_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cur_index = idx_q[IDX_W-1:0];

endmodule

// File: tb/tb_sccb_init_ctrl.sv
// Bench for sccb_init_ctrl: behavioural sender with random ack latency, random start noise,
// timeout, restart and asynchronous reset, checked against a table-derived timing model.
module tb_sccb_init_ctrl;

  localparam int unsigned PW    = 8;
  localparam int unsigned XF    = 40;
  localparam int unsigned DL    = 20;
  localparam int unsigned TMO   = 16;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam logic [15:0] TBL [5] = '{16'h1280, 16'hFFF0, 16'h1101, 16'h40D0, 16'hFFFF};

  logic          clk = 1'b0;
  logic          rst, start, sccb_ok;
  logic          reg_ok, busy, done, error;
  logic [7:0]    slave_id, reg_addr, value;
  logic [IW-1:0] cur_index;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: expected writes in order, with the number of delay entries preceding each one.
  int          n_wr;
  int          wr_idx  [8];
  logic [15:0] wr_pair [8];
  int          wr_dly  [8];
  int          tail_dly;

  always #5 clk = ~clk;

  sccb_init_ctrl #(
    .SLAVE_ID  (8'h42),
    .ROM_DEPTH (DEPTH),
    .PWRUP_CYC (PW),
    .XFER_CYC  (XF),
    .DELAY_CYC (DL),
    .ACK_TMO   (TMO),
    .CNT_W     (20),
    .TEST_TABLE(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reg_ok   (reg_ok),
    .sccb_ok  (sccb_ok),
    .slave_id (slave_id),
    .reg_addr (reg_addr),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cur_index(cur_index)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_model();
    int pend = 0;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      if (TBL[i] == 16'hFFFF) break;
      if (TBL[i] == 16'hFFF0) begin
        pend++;
      end else begin
        wr_idx[n_wr]  = i;
        wr_pair[n_wr] = TBL[i];
        wr_dly[n_wr]  = pend;
        pend          = 0;
        n_wr++;
      end
    end
    tail_dly = pend;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic noise(input bit en);
    return en && ($urandom_range(0, 5) == 0);
  endfunction

  // Runs one sequence; abort_after > 0 asserts reset inside the gap after that many writes.
  task automatic run_sequence(input bit noisy, input int fixed_lat, input int abort_after);
    int lo, hi, lat, exp_lo;
    bit hold_ok;
    pulse_start();
    check_eq("start_flags", {busy, done, error}, 3'b100);
    for (int k = 0; k < n_wr; k++) begin
      exp_lo  = ((k == 0) ? PW : XF) + 2 + wr_dly[k] * (DL + 2);
      lo      = 0;
      hold_ok = 1'b1;
      while (!reg_ok && lo < exp_lo + 64) begin
        lo++;
        if (k > 0 && {reg_addr, value} !== wr_pair[k-1]) hold_ok = 1'b0;
        start = noise(noisy);
        step();
      end
      start = 1'b0;
      check_eq("gap_len", lo, exp_lo);
      if (k > 0) check_eq("gap_hold", hold_ok, 1);
      if (!reg_ok) return;
      check_eq("pair", {reg_addr, value}, wr_pair[k]);
      check_eq("index", cur_index, wr_idx[k]);
      lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, TMO);
      hi  = 1;
      for (int h = 1; h < lat; h++) begin
        start = noise(noisy);
        step();
        if (reg_ok) hi++;
      end
      check_eq("ok_hold", hi, lat);
      sccb_ok = 1'b1;
      start   = noise(noisy);
      step();
      sccb_ok = 1'b0;
      start   = 1'b0;
      if (abort_after == k + 1) begin
        for (int w = $urandom_range(1, XF - 2); w > 0; w--) step();
        #2 rst = 1'b1;
        #1 check_eq("async_rst", {reg_ok, busy, done, error, cur_index, reg_addr, value}, 0);
        step();
        rst = 1'b0;
        step();
        check_eq("rst_idle", {busy, reg_ok}, 0);
        return;
      end
    end
    lo = 0;
    while (!done && lo < XF + 64 + tail_dly * (DL + 2)) begin
      lo++;
      step();
    end
    check_eq("done_lat", lo, XF + 2 + tail_dly * (DL + 2));
    check_eq("end_flags", {done, busy, error, reg_ok}, 4'b1000);
  endtask

  task automatic run_timeout();
    int lo, hi;
    pulse_start();
    lo = 0;
    while (!reg_ok && lo < PW + 64) begin
      lo++;
      step();
    end
    check_eq("tmo_lead", lo, PW + 2);
    hi = 0;
    while (reg_ok && hi < TMO + 8) begin
      hi++;
      step();
    end
    check_eq("tmo_len", hi, TMO);
    check_eq("tmo_flags", {error, reg_ok, busy, done}, 4'b1000);
    check_eq("tmo_index", cur_index, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    build_model();
    rst     = 1'b1;
    start   = 1'b0;
    sccb_ok = 1'b0;
    step();
    step();
    check_eq("rst_outputs", {reg_ok, busy, done, error, cur_index, reg_addr, value}, 0);
    check_eq("slave_id", slave_id, 8'h42);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("idle_hold", {busy, reg_ok, done}, 0);

    run_sequence(1'b0, 1, 0);
    for (int i = 0; i < 5; i++) step();
    check_eq("done_hold", {done, busy}, 2'b10);
    run_sequence(1'b0, 1, 0);
    run_sequence(1'b1, 0, 0);
    run_sequence(1'b0, TMO, 0);
    run_timeout();
    for (int i = 0; i < 5; i++) step();
    check_eq("err_hold", {error, busy, reg_ok}, 3'b100);
    run_sequence(1'b0, 0, 0);
    run_sequence(1'b1, 0, 2);
    run_sequence(1'b0, 1, 0);
    for (int r = 0; r < 4; r++) run_sequence(1'b1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
